// File: rtl/seg7_display_driver.sv
// Four-digit seven-segment driver: a free-running double-dabble converter turns the
// 16-bit count into display digits, and a refresh counter scans them onto the anodes.
module seg7_display_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    input  logic        hex_mode,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        ovf,
    output logic        upd
);
    localparam int CW = $clog2(REFRESH_DIV);

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} conv_state_t;

    conv_state_t     state, state_next;
    logic [3:0]      iter;
    logic [15:0]     bin_sr;
    logic [15:0]     value_cap;
    logic            hex_cap;
    logic [19:0]     bcd;
    logic [19:0]     bcd_adj;
    logic [3:0][3:0] disp_digit;
    logic            disp_hex;
    logic [CW-1:0]   refresh_cnt;
    logic [1:0]      digit_sel;
    logic [3:0]      lz;
    logic [6:0]      seg_next;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = SHIFT;
            SHIFT:   if (iter == 4'd15) state_next = LOAD;
            LOAD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Add-3 correction on every BCD nibble before the next shift
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 5; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iter       <= 4'd0;
            bin_sr     <= 16'd0;
            value_cap  <= 16'd0;
            hex_cap    <= 1'b0;
            bcd        <= 20'd0;
            disp_digit <= '0;
            disp_hex   <= 1'b0;
            ovf        <= 1'b0;
            upd        <= 1'b0;
        end else begin
            upd <= 1'b0;
            case (state)
                IDLE: begin
                    bin_sr    <= value;
                    value_cap <= value;
                    hex_cap   <= hex_mode;
                    bcd       <= 20'd0;
                    iter      <= 4'd0;
                end
                SHIFT: begin
                    {bcd, bin_sr} <= {bcd_adj, bin_sr} << 1;
                    iter          <= iter + 4'd1;
                end
                LOAD: begin
                    upd <= 1'b1;
                    if (hex_cap) begin
                        disp_digit <= value_cap;
                        disp_hex   <= 1'b1;
                        ovf        <= 1'b0;
                    end else if (bcd[19:16] != 4'd0) begin
                        disp_digit <= '0;
                        disp_hex   <= 1'b0;
                        ovf        <= 1'b1;
                    end else begin
                        disp_digit <= bcd[15:0];
                        disp_hex   <= 1'b0;
                        ovf        <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // A digit is a leading zero when it and every digit above it are zero
    always_comb begin
        lz    = 4'b0000;
        lz[3] = (disp_digit[3] == 4'd0);
        lz[2] = lz[3] && (disp_digit[2] == 4'd0);
        lz[1] = lz[2] && (disp_digit[1] == 4'd0);
    end

    always_comb begin
        seg_next = hex_to_seg(disp_digit[digit_sel]);
        if (ovf)                                      seg_next = 7'h3F;
        else if (BLANK_LZ && !disp_hex && lz[digit_sel]) seg_next = 7'h7F;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
            digit_sel   <= 2'd0;
            an          <= 4'b1111;
            seg         <= 7'h7F;
        end else begin
            an  <= ~(4'b0001 << digit_sel);
            seg <= seg_next;
            if (refresh_cnt == CW'(REFRESH_DIV - 1)) begin
                refresh_cnt <= '0;
                digit_sel   <= digit_sel + 2'd1;
            end else begin
                refresh_cnt <= refresh_cnt + CW'(1);
            end
        end
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_seg7_display_driver.sv
// Scoreboard bench for seg7_display_driver: stimulus pushes expected displays computed
// arithmetically from the count; a negedge monitor checks each refresh and the scan.
module tb_seg7_display_driver;
    localparam int REFRESH_DIV = 4;

    typedef struct packed {
        logic [3:0][6:0] segs;
        logic            ovf;
    } exp_t;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value;
    logic        hex_mode;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        ovf;
    logic        upd;

    int   total = 0;
    int   bad = 0;
    exp_t sb_q[$];

    seg7_display_driver #(.REFRESH_DIV(REFRESH_DIV), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .hex_mode(hex_mode),
        .an(an), .seg(seg), .dp(dp), .ovf(ovf), .upd(upd)
    );

    always #5 clk = ~clk;

    // Expected display from plain decimal/hex arithmetic on the count
    function automatic exp_t ref_model(input int v, input bit hx);
        exp_t e;
        int   p;
        e.ovf = 1'b0;
        p = 1;
        for (int k = 0; k < 4; k++) begin
            if (hx)                 e.segs[k] = SEG_TAB[(v >> (4 * k)) & 15];
            else if (v > 9999) begin
                e.segs[k] = 7'h3F;
                e.ovf     = 1'b1;
            end
            else if (k > 0 && v < p) e.segs[k] = 7'h7F;
            else                    e.segs[k] = SEG_TAB[(v / p) % 10];
            p = p * 10;
        end
        return e;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic apply_stimulus(input int v, input bit hx);
        value    = v[15:0];
        hex_mode = hx;
        sb_q.push_back(ref_model(v, hx));
    endtask

    task automatic wait_upd();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (upd === 1'b1) begin
                #1;
                return;
            end
        end
        total++;
        bad++;
        $display("[TB] FAIL upd_timeout: got no upd expected upd within 40 cycles");
        #1;
    endtask

    // Changes made after the IDLE capture must not reach the next LOAD
    task automatic mid_change(input int v, input bit hx);
        repeat ($urandom_range(3, 14)) @(negedge clk);
        value    = v[15:0];
        hex_mode = hx;
    endtask

    int   cyc;
    int   last_upd;
    int   scan_left;
    int   hold_cnt;
    int   idx;
    logic [3:0] prev_an;
    exp_t cur_exp;

    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            cyc       = 0;
            last_upd  = -1;
            scan_left = 0;
            hold_cnt  = 0;
            prev_an   = 4'b1111;
        end else begin
            cyc++;
            if (an == prev_an) hold_cnt++;
            else begin
                if (prev_an != 4'b1111) begin
                    check_output("an_hold", hold_cnt, REFRESH_DIV);
                    check_output("an_order", an, {prev_an[2:0], prev_an[3]});
                end
                prev_an  = an;
                hold_cnt = 1;
            end
            if (upd === 1'b1) begin
                if (last_upd < 0) check_output("first_upd_latency", cyc, 18);
                else              check_output("upd_period", cyc - last_upd, 18);
                last_upd = cyc;
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL scoreboard_empty: got upd expected no upd");
                end else begin
                    cur_exp = sb_q.pop_front();
                    check_output("ovf", ovf, cur_exp.ovf);
                    check_output("dp", dp, 1'b1);
                    scan_left = 4 * REFRESH_DIV;
                end
            end else if (scan_left > 0) begin
                case (an)
                    4'b1110: idx = 0;
                    4'b1101: idx = 1;
                    4'b1011: idx = 2;
                    4'b0111: idx = 3;
                    default: idx = -1;
                endcase
                if (idx < 0) check_output("an_onehot", an, 4'b1110);
                else         check_output($sformatf("seg_digit%0d", idx), seg, cur_exp.segs[idx]);
                scan_left--;
            end
        end
    end

    int  dir_v   [12] = '{16'hBEEF, 0, 7, 9999, 10000, 65535, 305, 305, 16'hFFFF, 5, 42, 42};
    bit  dir_h   [12] = '{1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0};
    int  dir_mv  [12] = '{-1, -1, -1, -1, -1, -1, -1, -1, -1, 42, 42, -1};
    bit  dir_mh  [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};

    initial begin
        int v;
        rst_n    = 1'b0;
        value    = 16'd1234;
        hex_mode = 1'b0;
        repeat (3) @(negedge clk);
        check_output("reset_an", an, 4'b1111);
        check_output("reset_seg", seg, 7'h7F);
        check_output("reset_dp", dp, 1'b1);
        check_output("reset_ovf", ovf, 1'b0);
        check_output("reset_upd", upd, 1'b0);
        sb_q.push_back(ref_model(1234, 1'b0));
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_output("first_an", an, 4'b1110);

        for (int i = 0; i < 12; i++) begin
            wait_upd();
            apply_stimulus(dir_v[i], dir_h[i]);
            if (dir_mv[i] >= 0) mid_change(dir_mv[i], dir_mh[i]);
        end

        wait_upd();
        apply_stimulus(65535, 1'b0);
        wait_upd();
        apply_stimulus(777, 1'b0);
        repeat (6) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_output("async_reset_an", an, 4'b1111);
        check_output("async_reset_seg", seg, 7'h7F);
        check_output("async_reset_ovf", ovf, 1'b0);
        check_output("async_reset_upd", upd, 1'b0);
        @(negedge clk);
        #1;
        sb_q.delete();
        sb_q.push_back(ref_model(777, 1'b0));
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            wait_upd();
            v = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 12000) : $urandom_range(0, 65535);
            apply_stimulus(v, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) mid_change($urandom_range(0, 65535), 1'($urandom_range(0, 1)));
        end

        wait_upd();
        repeat (17) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg7_display_driver.md
Name: seg7_display_driver

Overview:
Downstream consumer of the 16-bit FSM event counter. Converts the count to four display digits and time-multiplexes them onto the Basys 3 4-digit common-anode seven-segment display. In decimal mode it uses a sequential shift-add-3 (double-dabble) converter; in hex mode it shows the nibbles directly. It runs on the same slowed clock as the LFSR/FSM/counter chain, or on the board clock with REFRESH_DIV scaled to suit.

Parameters:
REFRESH_DIV, 100000, clock cycles each digit stays lit; range 2..2^20. The bench uses 4.
BLANK_LZ, 1, 1 blanks leading zero digits in decimal mode; digit 0 is never blanked.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
value  input  16  count to display, sampled by the converter
hex_mode  input  1  1 = hexadecimal display, 0 = decimal display
an  output  4  anode enables, active-low, one-hot; an[0] = rightmost digit
seg  output  7  segment drives, active-low, {g,f,e,d,c,b,a}; seg[0] = a
dp  output  1  decimal point, active-low; constant 1
ovf  output  1  high when the displayed value is a decimal overflow (value > 9999)
upd  output  1  one-cycle pulse when the display registers are refreshed

Behaviour:
- Single clock domain. Reset is asynchronous and active-low. All state clears immediately when rst_n is low.
- Reset values:
  - an=4'b1111, seg=7'h7F, dp=1, ovf=0, upd=0.
  - Digit registers = 0, digit_sel=0, refresh counter=0, converter state=IDLE.
- Converter FSM, 18-cycle period, free-running:
  - IDLE (1 cycle): capture value into shift reg, capture hex_mode, clear BCD scratch → SHIFT.
  - SHIFT (16 cycles, iteration counter 0..15): per cycle, add 3 to each BCD nibble ≥5, then shift {bcd,bin} left by 1. 20-bit BCD scratch. After iteration 15 → LOAD.
  - LOAD (1 cycle): commit to the display registers, assert upd for this cycle → IDLE.
- LOAD commit rules:
  - Hex mode: digits = captured value nibbles, ovf=0.
  - Decimal, BCD ten-thousands nibble ≠ 0 (value > 9999): all four digits show dash (7'h3F), ovf=1.
  - Decimal otherwise: digits = lower four BCD nibbles, ovf=0.
- Update latency: value and hex_mode changes take effect at most 36 cycles later, at a LOAD. Changes during SHIFT are ignored until the next IDLE.
- Refresh:
  - The counter counts 0..REFRESH_DIV-1. On wrap, digit_sel increments mod 4.
  - an = ~(1 << digit_sel). an and seg are registered and change on the same edge.
  - The first digit lights one cycle after reset deassertion: an=4'b1110.
- Segment map (active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10
  - A=08, b=03, C=46, d=21, E=06, F=0E
  - dash=3F, blank=7F
- Leading-zero blanking: applies only when BLANK_LZ=1 and in decimal mode. A digit k>0 is blank if it and every higher digit are 0. It does not apply to hex mode or the overflow display.
- Boundary cases:
  - value=0 decimal → shows "   0".
  - 9999 → "9999", ovf=0.
  - 10000 and 65535 → "----", ovf=1.
  - 16'hFFFF in hex → "FFFF".
- Reset mid-SHIFT: the partial conversion is discarded, the display blanks, and after release a full 18-cycle cycle restarts from IDLE.
- A hex_mode toggle mid-conversion does not corrupt the in-flight result; the result uses the hex_mode captured in IDLE.

Test Plan:
1. Reset held, value=16'h1234 → an=1111, seg=7F, ovf=0. Release, then wait 18 cycles → upd pulses once; decimal display scans digits 4,3,2,1 as seg 19,30,24,79 on an 1110,1101,1011,0111.
2. hex_mode=1, value=16'hBEEF, REFRESH_DIV=4 → digit 0..3 show 0E,06,06,03. Each an pattern is held exactly 4 cycles; the sequence wraps 1110→1101→1011→0111→1110.
3. Decimal sweep of value 0, 7, 9999, 10000, 65535 → displays "   0" (40 only on an0, others 7F), "   7", "9999", "----" with ovf=1, "----" with ovf=1.
4. BLANK_LZ=1, value=305 decimal → digit3 blank (7F), digits 2..0 = 30,40,12. Same value with hex_mode=1 → "0131" with no blanking.
5. Change value from 5 to 42 in the middle of SHIFT → the next LOAD still shows 5; the following LOAD shows 42. upd pulses every 18 cycles.
6. Assert rst_n low asynchronously between clock edges mid-SHIFT → outputs go to reset values without waiting for a clock edge. After release, the first upd occurs exactly 18 cycles later.
